peripheral_uart_tx_gen: RTL and testbench

Parametrised, buffered UART transmitter for the peripheral UART. It accepts words through a valid/ready push interface into an internal FIFO. It serialises each word LSB-first with a configurable data width (5..MAX_BITS), parity mode and stop-bit count. Optional CTS flow control is compiled in by macro. The block sits between the bus register file and the `tx` pad.

---
 rtl/peripheral_uart_pkg.sv | 32 +++
 rtl/peripheral_uart_tx_fifo.sv | 50 +++++
 rtl/peripheral_uart_tx_gen.sv | 172 +++++++++++++++++
 tb/tb_peripheral_uart_tx_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_uart_pkg.sv
// peripheral_uart_pkg
// Shared types and constants for the peripheral UART (TX now, RX later).
//   uart_tx_state_t : transmitter frame state
//   PAR_*           : parity mode encodings of cfg_parity_i
//   MIN_BITS        : smallest legal data width
//   clamp_last()    : data-bits-minus-1 clamped to MIN_BITS..max
package peripheral_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam int unsigned MIN_BITS = 5;

    // Returns the index of the last data bit, clamped to MIN_BITS-1..hi.
    function automatic logic [3:0] clamp_last(input logic [3:0] bits_m1,
                                              input logic [3:0] hi);
        if (bits_m1 < 4'(MIN_BITS - 1)) return 4'(MIN_BITS - 1);
        if (bits_m1 > hi)               return hi;
        return bits_m1;
    endfunction

endpackage

// File: rtl/peripheral_uart_tx_fifo.sv
// peripheral_uart_tx_fifo
// Synchronous FIFO with extra-MSB pointers; level = wptr - rptr.
//   clk_i, rstn_i   : clock, async active-low reset (empties the FIFO)
//   push_i, wdata_i : write request/data, ignored when full
//   pop_i, rdata_o  : read request, head word (valid when !empty_o)
//   full_o, empty_o : status from registered pointers only
//   level_o         : occupancy 0..DEPTH
module peripheral_uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             push_ok, pop_ok;

    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level_o = wptr - rptr;
    assign rdata_o = mem[rptr[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/peripheral_uart_tx_gen.sv
// peripheral_uart_tx_gen
// Buffered UART transmitter: FIFO push interface, LSB-first serialiser with
// 5..MAX_BITS data bits, none/even/odd/mark parity and 1 or 2 stop bits.
// Optional CTS gating is compiled in with `define PERIPHERAL_UART_TX_CTS_EN.
//   cfg_*_i          : line configuration, latched at each frame start
//   tx_data_i/valid_i/ready_o : push interface (ready = FIFO not full)
//   cts_ni           : clear-to-send, active-low (CTS build only)
//   tx_o, busy_o, done_o : registered line and frame status
//   fifo_empty_o, fifo_level_o : FIFO status
module peripheral_uart_tx_gen
    import peripheral_uart_pkg::*;
#(
    parameter int unsigned MAX_BITS   = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16,
    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cfg_en_i,
    input  logic [DIV_W-1:0]    cfg_div_i,
    input  logic [3:0]          cfg_bits_i,
    input  logic [1:0]          cfg_parity_i,
    input  logic                cfg_stop_bits_i,
    input  logic [MAX_BITS-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    input  logic                cts_ni,
    output logic                tx_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                fifo_empty_o,
    output logic [LW-1:0]       fifo_level_o
);

    uart_tx_state_t      state;
    logic [DIV_W-1:0]    baud_cnt, div_q;
    logic [3:0]          bit_cnt, last_q, last_n;
    logic [1:0]          par_q, stop_cnt;
    logic                stop2_q, par_bit, par_n, fin_q;
    logic [MAX_BITS-1:0] shift, fifo_rdata;
    logic                fifo_full, cts_ok, pop, tick, line_bit, xsum;

    peripheral_uart_tx_fifo #(.WIDTH(MAX_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (tx_valid_i),
        .wdata_i (tx_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty_o),
        .level_o (fifo_level_o)
    );

    assign tx_ready_o = !fifo_full;

`ifdef PERIPHERAL_UART_TX_CTS_EN
    // Two-flop synchroniser; resets to "not clear" so nothing starts early.
    logic [1:0] cts_sync;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cts_sync <= 2'b11;
        else         cts_sync <= {cts_sync[0], cts_ni};
    end
    assign cts_ok = !cts_sync[1];
`else
    logic unused_cts;
    assign unused_cts = cts_ni;
    assign cts_ok     = 1'b1;
`endif

    assign pop  = (state == IDLE) && cfg_en_i && !fifo_empty_o && cts_ok;
    assign tick = (baud_cnt == div_q);

    // Parity of the word being popped, over the clamped frame width only.
    always_comb begin
        last_n = clamp_last(cfg_bits_i, 4'(MAX_BITS - 1));
        xsum   = 1'b0;
        for (int i = 0; i < MAX_BITS; i++)
            if (4'(i) <= last_n) xsum ^= fifo_rdata[i];
        case (cfg_parity_i)
            PAR_EVEN: par_n = xsum;
            PAR_ODD:  par_n = ~xsum;
            PAR_MARK: par_n = 1'b1;
            default:  par_n = 1'b0;
        endcase
    end

    always_comb begin
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift[0];
            PARITY:  line_bit = par_bit;
            default: line_bit = 1'b1;
        endcase
    end

    // tx_o/busy_o trail the state by one clock, so the line drops on the
    // edge after the pop; fin_q delays done_o to the first idle line cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            fin_q    <= 1'b0;
            baud_cnt <= '0;
            div_q    <= '0;
            bit_cnt  <= '0;
            last_q   <= '0;
            par_q    <= PAR_NONE;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            stop_cnt <= '0;
            shift    <= '0;
        end else if (!cfg_en_i) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            fin_q    <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
        end else begin
            tx_o   <= line_bit;
            busy_o <= (state != IDLE);
            done_o <= fin_q;
            fin_q  <= 1'b0;
            if (state != IDLE) baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    state    <= START;
                    baud_cnt <= '0;
                    shift    <= fifo_rdata;
                    div_q    <= cfg_div_i;
                    last_q   <= last_n;
                    par_q    <= cfg_parity_i;
                    par_bit  <= par_n;
                    stop2_q  <= cfg_stop_bits_i;
                end
                START: if (tick) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
                DATA: if (tick) begin
                    shift <= {1'b0, shift[MAX_BITS-1:1]};
                    if (bit_cnt == last_q) begin
                        state    <= (par_q == PAR_NONE) ? STOP : PARITY;
                        stop_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: if (tick) begin
                    state    <= STOP;
                    stop_cnt <= '0;
                end
                STOP: if (tick) begin
                    if (stop_cnt[0] == stop2_q) begin
                        state <= IDLE;
                        fin_q <= 1'b1;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_uart_tx_gen.sv
module tb_peripheral_uart_tx_gen;

    localparam int MAXB  = 9;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int LW    = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic [DW-1:0]   div;
    logic [3:0]      bits;
    logic [1:0]      par;
    logic            stop2;
    logic [MAXB-1:0] data;
    logic            valid;
    logic            ready;
    logic            cts_n;
    logic            tx, busy, done, empty;
    logic [LW-1:0]   level;

    int n_cmp = 0;
    int n_err = 0;

    bit exp_tx[$];
    bit exp_dn[$];

    always #5 clk = ~clk;

    peripheral_uart_tx_gen #(.MAX_BITS(MAXB), .FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_en_i(en), .cfg_div_i(div),
        .cfg_bits_i(bits), .cfg_parity_i(par), .cfg_stop_bits_i(stop2),
        .tx_data_i(data), .tx_valid_i(valid), .tx_ready_o(ready),
        .cts_ni(cts_n), .tx_o(tx), .busy_o(busy), .done_o(done),
        .fifo_empty_o(empty), .fifo_level_o(level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int d, input int b, input int p, input int s);
        @(negedge clk);
        div = DW'(d); bits = 4'(b); par = 2'(p); stop2 = s[0];
    endtask

    task automatic push(input logic [MAXB-1:0] w);
        @(negedge clk);
        data = w; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    function automatic int nbits(input int bm1);
        int n = bm1 + 1;
        if (n < 5) n = 5;
        if (n > MAXB) n = MAXB;
        return n;
    endfunction

    // Reference frame: list of line levels, each held div+1 clocks, then one
    // idle cycle that carries the done pulse.
    function automatic void model_frame(input logic [MAXB-1:0] w, input int b,
                                        input int p, input int s, input int d);
        bit seq[$];
        bit x = 0;
        int n = nbits(b);
        seq.push_back(0);
        for (int i = 0; i < n; i++) begin
            seq.push_back(w[i]);
            x ^= w[i];
        end
        case (p)
            1: seq.push_back(x);
            2: seq.push_back(!x);
            3: seq.push_back(1);
            default: ;
        endcase
        seq.push_back(1);
        if (s != 0) seq.push_back(1);
        foreach (seq[k])
            for (int r = 0; r <= d; r++) begin
                exp_tx.push_back(seq[k]);
                exp_dn.push_back(0);
            end
        exp_tx.push_back(1);
        exp_dn.push_back(1);
    endfunction

    // FIFO preloaded with en=0; enable and compare every line cycle.
    task automatic run_stream(input string tag);
        @(negedge clk) en = 1'b1;
        @(posedge clk);
        for (int c = 0; c < exp_tx.size(); c++) begin
            @(posedge clk); #1;
            check($sformatf("%s cyc%0d tx/done", tag, c), {30'd0, tx, done},
                  {30'd0, exp_tx[c], exp_dn[c]});
        end
        @(negedge clk) en = 1'b0;
        exp_tx.delete();
        exp_dn.delete();
    endtask

    typedef struct {
        logic [MAXB-1:0] word;
        int bm1, p, s, d;
        int exp_len;
        int exp_n;
        logic [MAXB-1:0] exp_data;
        logic exp_pbit;
    } vec_t;

    vec_t vecs[7];
    logic smp[0:299];
    logic [MAXB-1:0] words[17];

    initial begin
        vecs[0] = '{9'h0A5, 7, 0, 0, 3, 40, 8, 9'h0A5, 1'b0};
        vecs[1] = '{9'h1FF, 6, 2, 1, 1, 22, 7, 9'h07F, 1'b0};
        vecs[2] = '{9'h0F3, 7, 1, 0, 0, 11, 8, 9'h0F3, 1'b0};
        vecs[3] = '{9'h155, 1, 3, 0, 2, 24, 5, 9'h015, 1'b1};
        vecs[4] = '{9'h1AB, 15, 1, 1, 0, 13, 9, 9'h1AB, 1'b0};
        vecs[5] = '{9'h0AA, 4, 2, 0, 1, 16, 5, 9'h00A, 1'b1};
        vecs[6] = '{9'h080, 7, 1, 0, 4, 55, 8, 9'h080, 1'b1};

        rstn = 1'b0; en = 1'b0; valid = 1'b0; data = '0; cts_n = 1'b0;
        div = '0; bits = 4'd7; par = 2'd0; stop2 = 1'b0;

        // Reset values
        #12;
        check("rst tx", {31'd0, tx}, 1);
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst ready", {31'd0, ready}, 1);
        check("rst empty", {31'd0, empty}, 1);
        check("rst level", {27'd0, level}, 0);
        @(negedge clk) rstn = 1'b1;

        // Push-to-line latency and done timing, 8N1 div=3, 0xA5
        begin
            int c;
            set_cfg(3, 7, 0, 0);
            en = 1'b1;
            @(negedge clk) data = 9'h0A5; valid = 1'b1;
            @(posedge clk); #1 valid = 1'b0;
            check("lat push-edge tx", {31'd0, tx}, 1);
            @(posedge clk); #1;
            check("lat pop-edge tx", {31'd0, tx}, 1);
            @(posedge clk); #1;
            check("lat start-edge tx", {31'd0, tx}, 0);
            check("lat start-edge busy", {31'd0, busy}, 1);
            c = 0;
            while (!done && c < 200) begin
                @(posedge clk); #1;
                c++;
            end
            check("lat done offset", c, 40);
            @(posedge clk); #1;
            check("lat done one-shot", {31'd0, done}, 0);
            @(negedge clk) en = 1'b0;
        end

        // Table vectors: one frame each, decode the captured line
        for (int v = 0; v < 7; v++) begin
            int c, per;
            logic [MAXB-1:0] got;
            logic stop_ok;
            set_cfg(vecs[v].d, vecs[v].bm1, vecs[v].p, vecs[v].s);
            push(vecs[v].word);
            @(negedge clk) en = 1'b1;
            @(posedge clk);
            c = 0;
            while (c < 300) begin
                @(posedge clk); #1;
                smp[c] = tx;
                if (done) break;
                c++;
            end
            @(negedge clk) en = 1'b0;
            per = vecs[v].d + 1;
            got = '0;
            for (int i = 0; i < vecs[v].exp_n; i++) got[i] = smp[(1 + i) * per];
            check($sformatf("vec%0d frame length", v), c, vecs[v].exp_len);
            check($sformatf("vec%0d start bit", v), {31'd0, smp[0]}, 0);
            check($sformatf("vec%0d data", v), {23'd0, got}, {23'd0, vecs[v].exp_data});
            if (vecs[v].p != 0)
                check($sformatf("vec%0d parity", v), {31'd0, smp[(1 + vecs[v].exp_n) * per]},
                      {31'd0, vecs[v].exp_pbit});
            stop_ok = 1'b1;
            for (int k = vecs[v].exp_len - (vecs[v].s + 1) * per; k < vecs[v].exp_len; k++)
                if (smp[k] !== 1'b1) stop_ok = 1'b0;
            check($sformatf("vec%0d stop bits", v), {31'd0, stop_ok}, 1);
        end

        // 17 pushes into a 16-deep FIFO while disabled, then 16 frames
        set_cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3),
                $urandom_range(0, 1));
        for (int i = 0; i < 17; i++) begin
            words[i] = MAXB'($urandom);
            push(words[i]);
            check($sformatf("fill ready after push %0d", i + 1), {31'd0, ready},
                  {31'd0, (i < 15)});
        end
        check("fill level", {27'd0, level}, 16);
        for (int i = 0; i < 16; i++)
            model_frame(words[i], bits, par, stop2, div);
        run_stream("full16");
        check("full16 empty after", {31'd0, empty}, 1);
        check("full16 level after", {27'd0, level}, 0);

        // Randomised bursts
        for (int r = 0; r < 4; r++) begin
            int n;
            logic [MAXB-1:0] w;
            n = $urandom_range(1, 12);
            set_cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                w = MAXB'($urandom);
                push(w);
                model_frame(w, bits, par, stop2, div);
            end
            check($sformatf("rand%0d level", r), {27'd0, level}, n);
            run_stream($sformatf("rand%0d", r));
        end

        // Abort mid-DATA, then resume with the next word
        begin
            int dn;
            set_cfg(3, 7, 0, 0);
            push(9'h03C);
            push(9'h055);
            @(negedge clk) en = 1'b1;
            repeat (12) @(posedge clk);
            @(negedge clk) en = 1'b0;
            @(posedge clk); #1;
            check("abort tx", {31'd0, tx}, 1);
            check("abort busy", {31'd0, busy}, 0);
            dn = 0;
            repeat (50) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            check("abort no done", dn, 0);
            check("abort level", {27'd0, level}, 1);
            model_frame(9'h055, 7, 0, 0, 3);
            run_stream("resume");
        end

        // Asynchronous reset mid-frame
        set_cfg(2, 7, 1, 1);
        push(9'h0F0);
        push(9'h00F);
        push(9'h133);
        @(negedge clk) en = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst tx", {31'd0, tx}, 1);
        check("arst busy", {31'd0, busy}, 0);
        check("arst done", {31'd0, done}, 0);
        check("arst ready", {31'd0, ready}, 1);
        check("arst empty", {31'd0, empty}, 1);
        check("arst level", {27'd0, level}, 0);
        @(negedge clk) rstn = 1'b1; en = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("post-arst idle line", {31'd0, tx}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
